ippcrc_crc32_stream: RTL and testbench

- Sequential, parametrised CRC-32 engine (poly 0x04C11DB7, MSB-first, init all-ones) for packet streams of configurable word width.
- Accumulates CRC across multi-word packets and handles partial last words through a byte count.
- Operates in generate mode (outputs the CRC) or check mode (compares the residue and flags an error).
- Sits in ippcrc beside the fixed-width combinational CRC cores; used by framers and deframers.

---
 rtl/ippcrc_crc32_stream_if.sv | 30 +++
 rtl/ippcrc_crc32_stream.sv | 137 +++++++++++++
 tb/tb_ippcrc_crc32_stream.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ippcrc_crc32_stream_if.sv
// Stream interface for ippcrc_crc32_stream: packet input words plus CRC result/status.
// master drives the packet stream, slave is the CRC engine.
interface ippcrc_crc32_stream_if #(
    parameter int DW   = 64,
    parameter int NBW  = 6,
    parameter int CNTW = 16
);
    logic            chk;
    logic            vld;
    logic            sop;
    logic            eop;
    logic [NBW-1:0]  nbyte;
    logic [DW-1:0]   di;
    logic            crc_vld;
    logic [31:0]     crc_out;
    logic            crc_err;
    logic            abort;
    logic [CNTW-1:0] pkt_cnt;
    logic [CNTW-1:0] err_cnt;

    modport master (
        output chk, vld, sop, eop, nbyte, di,
        input  crc_vld, crc_out, crc_err, abort, pkt_cnt, err_cnt
    );

    modport slave (
        input  chk, vld, sop, eop, nbyte, di,
        output crc_vld, crc_out, crc_err, abort, pkt_cnt, err_cnt
    );
endinterface

// File: rtl/ippcrc_crc32_stream.sv
// ippcrc_crc32_stream: streaming CRC-32 (poly 0x04C11DB7, MSB-first, init all-ones)
// with generate/check modes, partial last words and saturating packet/error counters.
// Build option: define IPPCRC_OUT_INV_EN to invert the reported CRC (CRC-32/BZIP2);
// leave it undefined for the plain register value (CRC-32/MPEG-2).
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | between packets; only a valid sop word starts a packet
// S_INPKT | inside a packet; words accumulate until eop, sop restarts
module ippcrc_crc32_stream #(
    parameter int DW   = 64,
    parameter int NBW  = 6,
    parameter int CNTW = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    ippcrc_crc32_stream_if.slave  io_bus
);
    localparam int          NB      = DW / 8;
    localparam logic [31:0] POLY    = 32'h04C1_1DB7;
    localparam logic [31:0] INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] RESIDUE = 32'hC704_DD7B;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_INPKT = 1'b1;

    logic [0:0]      r_state;
    logic [31:0]     r_crc;
    logic            r_chk;
    logic            r_crc_vld;
    logic [31:0]     r_crc_out;
    logic            r_crc_err;
    logic            r_abort;
    logic [CNTW-1:0] r_pkt_cnt;
    logic [CNTW-1:0] r_err_cnt;

    logic            w_start;
    logic            w_active;
    logic            w_chk;
    logic [31:0]     w_seed;
    logic [NBW-1:0]  w_nsel;
    logic [31:0]     w_nxt;
    logic [31:0]     w_out;
    logic            w_err;

    // One byte through the LFSR, wire order: bit 0 of the field is the byte MSB.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] v_c;
        logic        v_fb;
        v_c = c;
        for (int j = 0; j < 8; j++) begin
            v_fb = v_c[31] ^ d[j];
            v_c  = {v_c[30:0], 1'b0} ^ (v_fb ? POLY : 32'h0);
        end
        return v_c;
    endfunction

    // A sop word is accepted in either state and always reseeds and relatches the mode.
    always_comb begin
        w_start  = io_bus.vld & io_bus.sop;
        w_active = io_bus.vld & (io_bus.sop | (r_state == S_INPKT));
        w_seed   = w_start ? INIT : r_crc;
        w_chk    = w_start ? io_bus.chk : r_chk;
    end

    // Byte count used on this word: full word unless a short eop word says otherwise.
    always_comb begin
        w_nsel = NBW'(NB);
        if (io_bus.eop && (io_bus.nbyte != '0) && (io_bus.nbyte < NBW'(NB)))
            w_nsel = io_bus.nbyte;
    end

    // Byte-stage cascade with a tap after every stage; the selected tap is the next CRC.
    always_comb begin
        logic [31:0] v_c;
        v_c   = w_seed;
        w_nxt = w_seed;
        for (int k = 0; k < NB; k++) begin
            v_c = crc_byte(v_c, io_bus.di[8*k +: 8]);
            if (w_nsel == NBW'(k + 1))
                w_nxt = v_c;
        end
    end

    // Reported value and check-mode residue compare (always on the raw register value).
    always_comb begin
`ifdef IPPCRC_OUT_INV_EN
        w_out = ~w_nxt;
`else
        w_out = w_nxt;
`endif
        w_err = w_chk & (w_nxt != RESIDUE);
    end

    // Packet FSM, CRC accumulator, result registers and saturating counters.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_crc     <= INIT;
            r_chk     <= 1'b0;
            r_crc_vld <= 1'b0;
            r_crc_out <= 32'h0;
            r_crc_err <= 1'b0;
            r_abort   <= 1'b0;
            r_pkt_cnt <= '0;
            r_err_cnt <= '0;
        end else begin
            r_crc_vld <= 1'b0;
            r_abort   <= w_start & (r_state == S_INPKT);
            if (w_start)
                r_chk <= io_bus.chk;
            if (w_active) begin
                if (io_bus.eop) begin
                    r_state   <= S_IDLE;
                    r_crc     <= INIT;
                    r_crc_vld <= 1'b1;
                    r_crc_out <= w_out;
                    r_crc_err <= w_err;
                    if (r_pkt_cnt != '1)
                        r_pkt_cnt <= r_pkt_cnt + CNTW'(1);
                    if (w_err && (r_err_cnt != '1))
                        r_err_cnt <= r_err_cnt + CNTW'(1);
                end else begin
                    r_state <= S_INPKT;
                    r_crc   <= w_nxt;
                end
            end
        end
    end

    assign io_bus.crc_vld = r_crc_vld;
    assign io_bus.crc_out = r_crc_out;
    assign io_bus.crc_err = r_crc_err;
    assign io_bus.abort   = r_abort;
    assign io_bus.pkt_cnt = r_pkt_cnt;
    assign io_bus.err_cnt = r_err_cnt;
endmodule

// File: tb/tb_ippcrc_crc32_stream.sv
// Testbench for ippcrc_crc32_stream (DW=64): table of two-word packets plus
// hand-written sequences for back-to-back, abort, gaps, reset and saturation.
module tb_ippcrc_crc32_stream;
    localparam int DW   = 64;
    localparam int NBW  = 6;
    localparam int CNTW = 16;
    localparam logic [31:0] POLY = 32'h04C1_1DB7;
`ifdef IPPCRC_OUT_INV_EN
    localparam logic [31:0] CRC_123456789 = 32'hFC89_1918;
`else
    localparam logic [31:0] CRC_123456789 = 32'h0376_E6E7;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ippcrc_crc32_stream_if #(.DW(DW), .NBW(NBW), .CNTW(CNTW)) bus ();

    ippcrc_crc32_stream #(.DW(DW), .NBW(NBW), .CNTW(CNTW)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .io_bus(bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int unsigned exp_pkt = 0;
    int unsigned exp_errc = 0;

    typedef struct {
        logic        chk;
        logic [63:0] w0;
        logic [63:0] flip;
        logic [63:0] w1;
        logic [5:0]  nb1;
        logic [31:0] exp_out;
        logic        exp_err;
    } pkt_t;

    pkt_t tbl [6];

    // Text word (first char in the top byte) -> di layout: byte k at di[8k+7:8k], MSB at di[8k].
    function automatic logic [63:0] to_di(input logic [63:0] s);
        logic [63:0] r;
        for (int k = 0; k < 8; k++)
            for (int j = 0; j < 8; j++)
                r[8*k + j] = s[63 - 8*k - j];
        return r;
    endfunction

    // Reference bit-serial CRC over the first n bytes of a text word.
    function automatic logic [31:0] crc_model(input logic [31:0] seed, input logic [63:0] s, input int n);
        logic [31:0] c;
        logic [7:0]  v;
        logic        fb;
        c = seed;
        for (int b = 0; b < n; b++) begin
            v = s[63 - 8*b -: 8];
            for (int i = 7; i >= 0; i--) begin
                fb = c[31] ^ v[i];
                c  = {c[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
            end
        end
        return c;
    endfunction

    function automatic logic [31:0] fin(input logic [31:0] x);
`ifdef IPPCRC_OUT_INV_EN
        return ~x;
`else
        return x;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic e, input logic c,
                         input logic [5:0] nb, input logic [63:0] d);
        bus.vld   = v;
        bus.sop   = s;
        bus.eop   = e;
        bus.chk   = c;
        bus.nbyte = nb;
        bus.di    = d;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 64'h0);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    task automatic check_counters(input string name);
        check({name, " pkt_cnt"}, 32'(bus.pkt_cnt), exp_pkt);
        check({name, " err_cnt"}, 32'(bus.err_cnt), exp_errc);
    endtask

    task automatic check_all_zero(input string name);
        check({name, " crc_vld"}, 32'(bus.crc_vld), 32'h0);
        check({name, " crc_out"}, bus.crc_out, 32'h0);
        check({name, " crc_err"}, 32'(bus.crc_err), 32'h0);
        check({name, " abort"},   32'(bus.abort), 32'h0);
        check({name, " pkt_cnt"}, 32'(bus.pkt_cnt), 32'h0);
        check({name, " err_cnt"}, 32'(bus.err_cnt), 32'h0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] sw [3];
        logic [31:0] held;

        idle();
        rst = 1'b1;
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        tbl[0] = '{1'b0, "12345678", 64'h0, {"9", 56'h0}, 6'd1, CRC_123456789, 1'b0};
        tbl[1] = '{1'b1, "12345678", 64'h0, {8'h39, 32'hFC89_1918, 24'h0}, 6'd5, fin(32'hC704_DD7B), 1'b0};
        tbl[2] = '{1'b1, "12345678", 64'h8, {8'h39, 32'hFC89_1918, 24'h0}, 6'd5,
                   fin(crc_model(crc_model(32'hFFFF_FFFF, "!2345678", 8), {8'h39, 32'hFC89_1918, 24'h0}, 5)), 1'b1};
        tbl[3] = '{1'b0, "ABCDEFGH", 64'h0, "IJKLMNOP", 6'd0,
                   fin(crc_model(crc_model(32'hFFFF_FFFF, "ABCDEFGH", 8), "IJKLMNOP", 8)), 1'b0};
        tbl[4] = '{1'b0, "abcdefgh", 64'h0, "ijklmnop", 6'd9,
                   fin(crc_model(crc_model(32'hFFFF_FFFF, "abcdefgh", 8), "ijklmnop", 8)), 1'b0};
        tbl[5] = '{1'b0, "qrstuvwx", 64'h0, "yz012345", 6'd3,
                   fin(crc_model(crc_model(32'hFFFF_FFFF, "qrstuvwx", 8), "yz012345", 3)), 1'b0};

        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b1, 1'b0, tbl[i].chk, 6'd0, to_di(tbl[i].w0) ^ tbl[i].flip);
            tick();
            check($sformatf("tbl%0d vld_mid", i), 32'(bus.crc_vld), 32'h0);
            drive(1'b1, 1'b0, 1'b1, 1'b0, tbl[i].nb1, to_di(tbl[i].w1));
            tick();
            exp_pkt++;
            if (tbl[i].exp_err) exp_errc++;
            check($sformatf("tbl%0d crc_vld", i), 32'(bus.crc_vld), 32'h1);
            check($sformatf("tbl%0d crc_out", i), bus.crc_out, tbl[i].exp_out);
            check($sformatf("tbl%0d crc_err", i), 32'(bus.crc_err), 32'(tbl[i].exp_err));
            check_counters($sformatf("tbl%0d", i));
            idle();
            tick();
            check($sformatf("tbl%0d vld_after", i), 32'(bus.crc_vld), 32'h0);
            check($sformatf("tbl%0d out_held", i), bus.crc_out, tbl[i].exp_out);
        end

        // Three back-to-back single-word packets.
        sw[0] = "QRSTUVWX";
        sw[1] = "01234567";
        sw[2] = "zyxwvuts";
        drive(1'b1, 1'b1, 1'b1, 1'b0, 6'd0, to_di(sw[0]));
        tick();
        for (int i = 0; i < 3; i++) begin
            if (i < 2) drive(1'b1, 1'b1, 1'b1, 1'b0, 6'd0, to_di(sw[i + 1]));
            else idle();
            check($sformatf("b2b%0d crc_vld", i), 32'(bus.crc_vld), 32'h1);
            check($sformatf("b2b%0d crc_out", i), bus.crc_out, fin(crc_model(32'hFFFF_FFFF, sw[i], 8)));
            tick();
        end
        exp_pkt += 3;
        check("b2b end crc_vld", 32'(bus.crc_vld), 32'h0);
        check_counters("b2b");

        // Abort: restart by sop inside a packet; result covers only the restarted packet.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 6'd0, to_di("ABCDEFGH"));
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, to_di("IJKLMNOP"));
        tick();
        check("abort before", 32'(bus.abort), 32'h0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 6'd0, to_di("12345678"));
        tick();
        check("abort pulse", 32'(bus.abort), 32'h1);
        check("abort no vld", 32'(bus.crc_vld), 32'h0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 6'd1, to_di({"9", 56'h0}));
        tick();
        exp_pkt++;
        check("abort cleared", 32'(bus.abort), 32'h0);
        check("abort crc_vld", 32'(bus.crc_vld), 32'h1);
        check("abort crc_out", bus.crc_out, CRC_123456789);
        check_counters("abort");
        idle();
        tick();

        // Five idle cycles mid-packet with garbage on the qualified controls.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 6'd0, to_di("12345678"));
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b1, 6'd2, to_di("zzzzzzzz"));
            tick();
            check($sformatf("gap%0d crc_vld", i), 32'(bus.crc_vld), 32'h0);
        end
        drive(1'b1, 1'b0, 1'b1, 1'b0, 6'd1, to_di({"9", 56'h0}));
        tick();
        exp_pkt++;
        check("gap crc_vld", 32'(bus.crc_vld), 32'h1);
        check("gap crc_out", bus.crc_out, CRC_123456789);
        check("gap crc_err", 32'(bus.crc_err), 32'h0);
        check_counters("gap");
        idle();
        tick();

        // Words without sop in IDLE are ignored.
        held = bus.crc_out;
        drive(1'b1, 1'b0, 1'b1, 1'b1, 6'd0, to_di("ABCDEFGH"));
        tick();
        check("idle eop crc_vld", 32'(bus.crc_vld), 32'h0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 6'd0, to_di("IJKLMNOP"));
        tick();
        drive(1'b1, 1'b0, 1'b1, 1'b1, 6'd0, to_di("QRSTUVWX"));
        tick();
        check("idle nosop crc_vld", 32'(bus.crc_vld), 32'h0);
        check("idle crc_out held", bus.crc_out, held);
        check_counters("idle");
        idle();
        tick();

        // Reset on the cycle after sop, coinciding with an eop word: reset wins.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 6'd0, to_di("12345678"));
        tick();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 6'd1, to_di({"9", 56'h0}));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_pkt = 0;
        exp_errc = 0;
        check_all_zero("midrst");
        drive(1'b1, 1'b0, 1'b1, 1'b0, 6'd1, to_di({"9", 56'h0}));
        tick();
        check("midrst discarded", 32'(bus.crc_vld), 32'h0);
        idle();
        tick();
        check_counters("midrst");

        // Error counter saturation via back-to-back bad check-mode packets.
        for (int i = 1; i <= 65535; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b1, 6'd0, to_di("12345678"));
            tick();
            if (i == 65534) check("sat err_cnt pre", 32'(bus.err_cnt), 32'h0000_FFFE);
        end
        check("sat err_cnt full", 32'(bus.err_cnt), 32'h0000_FFFF);
        check("sat pkt_cnt full", 32'(bus.pkt_cnt), 32'h0000_FFFF);
        check("sat crc_err", 32'(bus.crc_err), 32'h1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b1, 6'd0, to_di("12345678"));
            tick();
        end
        idle();
        tick();
        check("sat err_cnt held", 32'(bus.err_cnt), 32'h0000_FFFF);
        check("sat pkt_cnt held", 32'(bus.pkt_cnt), 32'h0000_FFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
